// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package im_loader_pkg;

  localparam int unsigned IM_DEFAULT_ADDR_WIDTH = 8;
  localparam logic [31:0] CPU_RESET_PC          = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } ld_state_t;

endpackage

// File: rtl/im_loader.sv
// Boot-time loader: streams instruction words into IM from address 0,
// holds the CPU in reset while loading, then releases it.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IM_DEFAULT_ADDR_WIDTH,
  parameter int RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           checksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HW    = $clog2(RST_HOLD + 1) + 1;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [HW-1:0]       HOLD_END = HW'(RST_HOLD);

  ld_state_t             state, state_n;
  logic [HW-1:0]         hold_cnt, hold_cnt_n;
  logic [ADDR_WIDTH:0]   word_count_n;
  logic [31:0]           checksum_n;
  logic                  im_we_n;
  logic [ADDR_WIDTH-1:0] im_addr_n;
  logic [31:0]           im_wdata_n;
  logic                  accept;

  // State and every output are registered; status flags are decoded from
  // the next state so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      word_count <= '0;
      checksum   <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rstn   <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      word_count <= word_count_n;
      checksum   <= checksum_n;
      im_we      <= im_we_n;
      im_addr    <= im_addr_n;
      im_wdata   <= im_wdata_n;
      s_ready    <= (state_n == LOAD);
      busy       <= (state_n == LOAD) || (state_n == HOLD);
      done       <= (state_n == RUN);
      err        <= (state_n == ERR);
      cpu_rstn   <= (state_n == RUN);
    end
  end

  // Next-state, write-port and counter logic.
  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    word_count_n = word_count;
    checksum_n   = checksum;
    im_we_n      = 1'b0;
    im_addr_n    = im_addr;
    im_wdata_n   = im_wdata;
    accept       = s_valid & s_ready;

    unique case (state)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_n      = LOAD;
          word_count_n = '0;
          checksum_n   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          im_we_n      = 1'b1;
          im_addr_n    = word_count[ADDR_WIDTH-1:0];
          im_wdata_n   = s_data;
          word_count_n = word_count + (ADDR_WIDTH + 1)'(1);
          checksum_n   = checksum ^ s_data;
          if (s_last) begin
            state_n    = HOLD;
            hold_cnt_n = '0;
          end else if (word_count == LAST_IDX) begin
            state_n = ERR;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_END) begin
          state_n = RUN;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive IM word addresses starting at 0. It holds the CPU in reset while loading, then releases it so execution starts at PC 0x00000000. This lets a program be loaded by hardware rather than by backdoor ROM initialisation.

## Interface
Parameters:
- ADDR_WIDTH, 8, IM word-address width; DEPTH = 2**ADDR_WIDTH words.
- RST_HOLD, 4, cycles the CPU reset stays asserted after the last write.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a (re)load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  32  instruction word.
- s_last  in  1  marks final word of the program.
- im_we  out  1  IM write enable.
- im_addr  out  ADDR_WIDTH  IM word address; CPU byte PC = 4*im_addr.
- im_wdata  out  32  IM write data.
- cpu_rstn  out  1  active-low reset to the CPU.
- busy  out  1  high in LOAD or HOLD.
- done  out  1  high in RUN.
- err  out  1  high in ERR.
- word_count  out  ADDR_WIDTH+1  words accepted in current load.
- checksum  out  32  running XOR of accepted words.

## Operation
- States: IDLE, LOAD, HOLD, RUN, ERR.
- Reset (any time, including mid-load): state IDLE; s_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_rstn 0, busy 0, done 0, err 0, word_count 0, checksum 0. A partially written IM is left as-is.
- IDLE: start -> LOAD; word_count and checksum cleared.
- LOAD:
  - s_ready 1.
  - A beat is accepted when s_valid & s_ready.
  - For each accepted beat: write s_data to address word_count[ADDR_WIDTH-1:0]; word_count += 1; checksum ^= s_data.
  - Accepted beat with s_last -> HOLD.
  - Accepted beat without s_last at word_count == DEPTH-1 (the last address) -> ERR; that word is still written.
- HOLD: s_ready 0; internal counter runs RST_HOLD cycles, then -> RUN.
- RUN: cpu_rstn 1, done 1. start -> LOAD; counters are cleared and cpu_rstn falls.
- ERR: err 1, cpu_rstn 0. start -> LOAD, clearing err and counters.
- start is ignored in LOAD and HOLD.
- s_data and s_last are don't-care when no beat is accepted.
- word_count saturates by construction: the maximum value is DEPTH, reached only when the last accepted beat is at address DEPTH-1, which enters either HOLD or ERR.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- start sampled at edge t -> state LOAD, s_ready 1, busy 1, cpu_rstn 0 after edge t.
- Beat accepted at edge t:
  - im_we 1 for exactly one cycle after edge t, with the matching im_addr and im_wdata.
  - word_count and checksum update at the same edge.
- Back-to-back beats give back-to-back write pulses; a stall in s_valid gives im_we 0 for those cycles.
- Last beat at edge t:
  - s_ready 0 after edge t.
  - cpu_rstn stays 0 through edge t+RST_HOLD.
  - cpu_rstn 1 and done 1 after edge t+RST_HOLD+1.
- The final IM write precedes CPU reset release by at least RST_HOLD cycles.
- start in RUN at edge t: cpu_rstn 0, done 0 and s_ready 1 all after edge t.

## Structure
- Shared package im_loader_pkg holds:
  - the state enum (IDLE, LOAD, HOLD, RUN, ERR);
  - constants IM_DEFAULT_ADDR_WIDTH = 8 and CPU_RESET_PC = 32'h00000000.
- Single module; the HOLD counter is inline. No sub-module.

## Test plan
- Nominal load: start, then words 0x20080005, 0x20090003, 0x01095020 back-to-back, s_last on the third -> im_we pulses at addr 0, 1, 2 with those data; word_count 3; checksum 0x01085026; cpu_rstn rises exactly RST_HOLD+1 edges after the third accept; done 1.
- Backpressure and gaps: same three words with s_valid low for 2 cycles between beats -> im_we low during the gaps; same addresses, data and checksum; no duplicate writes.
- Overflow with ADDR_WIDTH=2: four words, none with s_last -> writes at addr 0-3, then err 1, cpu_rstn stays 0, s_ready 0; start then a single word with s_last -> err clears, word_count 1, RUN reached.
- Reload from RUN: after the nominal load, start -> cpu_rstn 0 and done 0 on the next edge; reload one word 0x00000000 with s_last -> word_count 1, checksum 0, RUN reached.
- Async reset mid-LOAD: assert rst between edges after 2 accepted words -> all outputs take their reset values immediately, without waiting for an edge; state IDLE; s_valid is then ignored until start.
- start during HOLD and during LOAD -> ignored: no counter clear, RUN timing unchanged.
